pipe_ctrl: RTL and testbench

Pipeline stall/flush controller for the five-stage core. Merges per-stage stall requests into the 6-bit `stall` vector consumed by every pipeline register (pc, if_id, id_ex, ex_mem, mem_wb). It sequences multi-cycle EX operations (madd/msub/div) by holding EX for a counted number of cycles. It also issues one-cycle pipeline flushes on exceptions and on a stall watchdog timeout.

---
 rtl/pipe_ctrl_pkg.sv | 44 ++++
 rtl/pipe_ctrl_stall_watchdog.sv | 64 ++++++
 rtl/pipe_ctrl.sv | 138 +++++++++++++
 tb/tb_pipe_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline stall/flush controller:
//   - stall vector encodings (bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB)
//   - controller FSM state type
//   - Enable/Disable, ZeroWord, watchdog counter width
//   - stall_decode(): priority merge of per-stage stall requests
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

    localparam logic [5:0] StallNone = 6'b000000;
    localparam logic [5:0] StallIF   = 6'b000011;
    localparam logic [5:0] StallID   = 6'b000111;
    localparam logic [5:0] StallEX   = 6'b001111;
    localparam logic [5:0] StallMEM  = 6'b011111;

    localparam logic        Enable   = 1'b1;
    localparam logic        Disable  = 1'b0;
    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    // Wide enough for TIMEOUT up to 1023.
    localparam int unsigned WdWidth = 10;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBusy  = 2'd1,
        StFlush = 2'd2
    } pipe_state_e;

    // Highest requesting stage wins; holding a stage holds everything upstream.
    function automatic logic [5:0] stall_decode(
        input logic req_mem,
        input logic req_ex,
        input logic req_id,
        input logic req_if
    );
        if (req_mem)     return StallMEM;
        else if (req_ex) return StallEX;
        else if (req_id) return StallID;
        else if (req_if) return StallIF;
        else             return StallNone;
    endfunction

endpackage

// File: rtl/pipe_ctrl_stall_watchdog.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_stall_watchdog
// Counts consecutive cycles with the PC held and fires a one-cycle pulse when
// the count reaches TIMEOUT. Also keeps the sticky timeout flag and a
// saturating count of all PC-held cycles.
// Ports:
//   clk            in   core clock
//   rst_n          in   asynchronous active-low reset
//   i_stall_pc     in   stall[0] of the merged stall vector
//   i_flush        in   controller is in its FLUSH state
//   o_fire         out  combinational pulse: TIMEOUT-th consecutive held cycle
//   o_timeout      out  sticky watchdog flag
//   o_stall_cycles out  saturating count of PC-held cycles
// ---------------------------------------------------------------------------
module pipe_ctrl_stall_watchdog
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_stall_pc,
    input  logic             i_flush,
    output logic             o_fire,
    output logic             o_timeout,
    output logic [CNT_W-1:0] o_stall_cycles
);

    localparam logic [WdWidth-1:0] WdLast = WdWidth'(TIMEOUT - 1);

    logic [WdWidth-1:0] r_wd;
    logic               r_timeout;
    logic [CNT_W-1:0]   r_stall_cycles;
    logic               w_fire;

    // r_wd holds the number of earlier consecutive held cycles, so the
    // TIMEOUT-th held cycle is the one that sees TIMEOUT-1.
    assign w_fire = i_stall_pc && (r_wd == WdLast);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd           <= '0;
            r_timeout      <= Disable;
            r_stall_cycles <= '0;
        end else begin
            if (w_fire || !i_stall_pc || i_flush)
                r_wd <= '0;
            else
                r_wd <= r_wd + WdWidth'(1);

            if (w_fire)
                r_timeout <= Enable;

            if (i_stall_pc && (r_stall_cycles != '1))
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
        end
    end

    assign o_fire         = w_fire;
    assign o_timeout      = r_timeout;
    assign o_stall_cycles = r_stall_cycles;

endmodule

// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl
// Pipeline stall/flush controller for the five-stage core. Merges per-stage
// stall requests into the 6-bit stall vector, holds EX for counted
// multi-cycle operations, and issues one-cycle flushes on exceptions and on
// stall watchdog timeout.
// Ports:
//   clk           in   core clock
//   rst           in   asynchronous active-low reset
//   stallreq_if   in   fetch not ready
//   stallreq_id   in   load-use hazard
//   stallreq_ex   in   EX external stall request
//   stallreq_mem  in   data access not ready
//   mc_start      in   EX begins a multi-cycle op this cycle
//   mc_len [5:0]  in   total EX occupancy of that op, in cycles
//   mc_cancel     in   abort running multi-cycle op
//   flush_req     in   exception taken in MEM
//   stall [5:0]   out  hold per stage (bit0 PC .. bit5 WB)
//   flush         out  registered one-cycle flush pulse
//   mc_busy       out  multi-cycle op in progress
//   timeout       out  sticky watchdog flag
//   stall_cycles  out  saturating count of PC-held cycles
// ---------------------------------------------------------------------------
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_if,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             stallreq_mem,
    input  logic             mc_start,
    input  logic [5:0]       mc_len,
    input  logic             mc_cancel,
    input  logic             flush_req,
    output logic [5:0]       stall,
    output logic             flush,
    output logic             mc_busy,
    output logic             timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    pipe_state_e r_state;
    pipe_state_e w_state_nxt;
    logic [5:0]  r_rem;
    logic [5:0]  w_rem_nxt;
    logic        w_hold_ex;
    logic        w_fire;
    logic        w_flush;
    logic [5:0]  w_stall_raw;
    logic        w_stall_pc;

    assign w_flush = (r_state == StFlush);

    // EX hold is derived without the watchdog fire so that the fire ->
    // next-state path never loops back into stall[0].
    always_comb begin
        w_hold_ex = Disable;
        if (!flush_req) begin
            case (r_state)
                StIdle:  w_hold_ex = mc_start && (mc_len >= 6'd2);
                StBusy:  w_hold_ex = !mc_cancel && (r_rem != '0);
                default: w_hold_ex = Disable;
            endcase
        end
    end

    always_comb begin
        w_stall_raw = stall_decode(stallreq_mem, stallreq_ex || w_hold_ex,
                                   stallreq_id, stallreq_if);
    end

    assign stall = (!rst || w_flush) ? StallNone : w_stall_raw;

    // Same as stall[0] whenever the watchdog is out of reset; the reset term
    // is left out so the reset net only ever reaches flops asynchronously.
    assign w_stall_pc = w_stall_raw[0] && !w_flush;

    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        if (flush_req || w_fire) begin
            w_state_nxt = StFlush;
            w_rem_nxt   = '0;
        end else if (mc_cancel && (r_state == StBusy)) begin
            w_state_nxt = StIdle;
            w_rem_nxt   = '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (mc_start && (mc_len >= 6'd2)) begin
                        w_state_nxt = StBusy;
                        w_rem_nxt   = mc_len - 6'd2;
                    end
                end
                StBusy: begin
                    if (r_rem != '0)
                        w_rem_nxt = r_rem - 6'd1;
                    else
                        w_state_nxt = StIdle;
                end
                StFlush: w_state_nxt = StIdle;
                default: w_state_nxt = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
            r_rem   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
        end
    end

    assign flush   = w_flush;
    assign mc_busy = (r_state == StBusy);

    pipe_ctrl_stall_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_stall_watchdog (
        .clk            (clk),
        .rst_n          (rst),
        .i_stall_pc     (w_stall_pc),
        .i_flush        (w_flush),
        .o_fire         (w_fire),
        .o_timeout      (timeout),
        .o_stall_cycles (stall_cycles)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl
// Directed bench for pipe_ctrl. Inputs change 1 time unit after the rising
// edge; outputs are sampled 2 units later, inside the same cycle.
// ---------------------------------------------------------------------------
module tb_pipe_ctrl;

    localparam int unsigned TB_TIMEOUT = 6;
    localparam int unsigned TB_CNT_W   = 32;

    logic                clk = 1'b0;
    logic                rst;
    logic                stallreq_if;
    logic                stallreq_id;
    logic                stallreq_ex;
    logic                stallreq_mem;
    logic                mc_start;
    logic [5:0]          mc_len;
    logic                mc_cancel;
    logic                flush_req;
    logic [5:0]          stall;
    logic                flush;
    logic                mc_busy;
    logic                timeout;
    logic [TB_CNT_W-1:0] stall_cycles;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(
        .TIMEOUT (TB_TIMEOUT),
        .CNT_W   (TB_CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_if  (stallreq_if),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .stallreq_mem (stallreq_mem),
        .mc_start     (mc_start),
        .mc_len       (mc_len),
        .mc_cancel    (mc_cancel),
        .flush_req    (flush_req),
        .stall        (stall),
        .flush        (flush),
        .mc_busy      (mc_busy),
        .timeout      (timeout),
        .stall_cycles (stall_cycles)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stallreq_if  = 1'b0;
        stallreq_id  = 1'b0;
        stallreq_ex  = 1'b0;
        stallreq_mem = 1'b0;
        mc_start     = 1'b0;
        mc_len       = 6'd0;
        mc_cancel    = 1'b0;
        flush_req    = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();

        // Reset: everything zero, stall forced low even with a MEM request.
        next_cycle();
        stallreq_mem = 1'b1;
        #2;
        check("rst_stall",   32'(stall), 32'h00);
        check("rst_flush",   32'(flush), 32'h0);
        check("rst_busy",    32'(mc_busy), 32'h0);
        check("rst_timeout", 32'(timeout), 32'h0);
        check("rst_cycles",  stall_cycles, 32'd0);
        next_cycle();
        clear_inputs();
        rst = 1'b1;
        next_cycle();

        // ID + MEM together: MEM wins.
        stallreq_id  = 1'b1;
        stallreq_mem = 1'b1;
        #2;
        check("idmem_stall", 32'(stall), 32'h1f);
        next_cycle();
        clear_inputs();
        #2;
        check("idmem_after", 32'(stall), 32'h00);
        check("idmem_cycles", stall_cycles, 32'd1);

        // mc_len=5: held T..T+3, clear T+4, busy T+1..T+4; restart at T+1 ignored.
        next_cycle();
        mc_len = 6'd5;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) next_cycle();
            mc_start = (i < 2);
            #2;
            check($sformatf("mc5_stall_%0d", i), 32'(stall), (i < 4) ? 32'h0f : 32'h00);
            check($sformatf("mc5_busy_%0d", i), 32'(mc_busy), (i >= 1) ? 32'h1 : 32'h0);
        end
        next_cycle();
        clear_inputs();
        #2;
        check("mc5_done_busy", 32'(mc_busy), 32'h0);
        check("mc5_cycles", stall_cycles, 32'd5);

        // mc_len=5 with a MEM stall at T+2: hold still ends after T+3.
        next_cycle();
        mc_len = 6'd5;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) next_cycle();
            mc_start     = (i == 0);
            stallreq_mem = (i == 2);
            #2;
            check($sformatf("mcmem_stall_%0d", i), 32'(stall),
                  (i == 2) ? 32'h1f : ((i < 4) ? 32'h0f : 32'h00));
        end
        next_cycle();
        clear_inputs();
        #2;
        check("mcmem_busy", 32'(mc_busy), 32'h0);
        check("mcmem_cycles", stall_cycles, 32'd9);

        // Flush while BUSY with rem=3.
        next_cycle();
        mc_start = 1'b1;
        mc_len   = 6'd6;
        next_cycle();
        clear_inputs();
        next_cycle();
        flush_req   = 1'b1;
        stallreq_ex = 1'b1;
        #2;
        check("fl_busy_pre", 32'(mc_busy), 32'h1);
        check("fl_flush_pre", 32'(flush), 32'h0);
        next_cycle();
        clear_inputs();
        stallreq_if = 1'b1;
        #2;
        check("fl_flush", 32'(flush), 32'h1);
        check("fl_stall", 32'(stall), 32'h00);
        check("fl_busy", 32'(mc_busy), 32'h0);
        next_cycle();
        clear_inputs();
        #2;
        check("fl_flush_end", 32'(flush), 32'h0);
        check("fl_busy_end", 32'(mc_busy), 32'h0);
        check("fl_cycles", stall_cycles, 32'd12);

        // flush_req and mc_start together: flush wins, op never starts.
        next_cycle();
        flush_req   = 1'b1;
        mc_start    = 1'b1;
        mc_len      = 6'd5;
        stallreq_id = 1'b1;
        next_cycle();
        clear_inputs();
        #2;
        check("fw_flush", 32'(flush), 32'h1);
        check("fw_busy", 32'(mc_busy), 32'h0);
        next_cycle();
        #2;
        check("fw_flush_end", 32'(flush), 32'h0);
        check("fw_busy_end", 32'(mc_busy), 32'h0);
        check("fw_stall_end", 32'(stall), 32'h00);
        check("fw_cycles", stall_cycles, 32'd13);

        // Watchdog: fetch stalled continuously; fires after TB_TIMEOUT cycles.
        next_cycle();
        stallreq_if = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) next_cycle();
            #2;
            check($sformatf("wd_stall_%0d", i), 32'(stall), (i == 6) ? 32'h00 : 32'h03);
            check($sformatf("wd_flush_%0d", i), 32'(flush), (i == 6) ? 32'h1 : 32'h0);
            check($sformatf("wd_timeout_%0d", i), 32'(timeout), (i >= 6) ? 32'h1 : 32'h0);
        end
        next_cycle();
        clear_inputs();
        #2;
        check("wd_sticky", 32'(timeout), 32'h1);
        check("wd_cycles", stall_cycles, 32'd22);

        // Asynchronous reset in the middle of a BUSY run.
        next_cycle();
        mc_start = 1'b1;
        mc_len   = 6'd10;
        next_cycle();
        clear_inputs();
        next_cycle();
        #2;
        check("ar_busy_pre", 32'(mc_busy), 32'h1);
        check("ar_stall_pre", 32'(stall), 32'h0f);
        rst = 1'b0;
        #1;
        check("ar_stall", 32'(stall), 32'h00);
        check("ar_busy", 32'(mc_busy), 32'h0);
        check("ar_flush", 32'(flush), 32'h0);
        check("ar_cycles", stall_cycles, 32'd0);
        check("ar_timeout", 32'(timeout), 32'h0);
        next_cycle();
        rst = 1'b1;
        next_cycle();
        #2;
        check("ar_idle_busy", 32'(mc_busy), 32'h0);
        check("ar_idle_stall", 32'(stall), 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
